// File: rtl/card_dealer_if.sv
// card_dealer_if: bundles the game-FSM/RAM-facing signals of the card dealer.
//   master : game FSM / card RAM side (drives start, request, memData)
//   slave  : card_dealer (drives address, strobe and dealt-card fields)
// Handshake: request is a level that the dealer samples only while idle with
// start high and cards left; it is accepted on that edge and needs no ready.
// cardValid pulses for exactly one cycle when card/points/isAce/badCard take
// new values. There is no backpressure. Requests seen while busy or empty are
// dropped, not queued.
interface card_dealer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
);
  logic              start;
  logic              request;
  logic [DATA_W-1:0] memData;
  logic [ADDR_W-1:0] nextA;
  logic              memClock;
  logic              wren;
  logic [DATA_W-1:0] card;
  logic [3:0]        points;
  logic              isAce;
  logic              badCard;
  logic              cardValid;
  logic              busy;
  logic              empty;
  logic [ADDR_W-1:0] remaining;

  modport master (
    output start, request, memData,
    input  nextA, memClock, wren, card, points, isAce, badCard,
           cardValid, busy, empty, remaining
  );

  modport slave (
    input  start, request, memData,
    output nextA, memClock, wren, card, points, isAce, badCard,
           cardValid, busy, empty, remaining
  );
endinterface

// File: rtl/card_dealer.sv
// card_dealer: deals a shuffled deck from the card RAM one card per request,
// reading addresses in ascending order. It returns the card code together with
// its blackjack point value, and tracks how many cards remain.
// Ports:
//   clock     : system clock, all logic on posedge
//   reset     : synchronous active-high reset, takes priority over start
//   bus       : card_dealer_if.slave (start/request/memData in; nextA,
//               memClock, wren, card, points, isAce, badCard, cardValid,
//               busy, empty, remaining out)
//   dbg_state : current FSM state (0 IDLE, 1 ADDR, 2 READ, 3 CAPTURE)
module card_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 4
) (
  input  logic        clock,
  input  logic        reset,
  card_dealer_if.slave bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DECK = ADDR_W'(DECK_SIZE);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       code;
  logic              deck_empty;

  assign code       = 32'(bus.memData);
  assign deck_empty = (ptr == DECK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      bus.card    <= '0;
      bus.points  <= 4'd0;
      bus.isAce   <= 1'b0;
      bus.badCard <= 1'b0;
    end else if (!bus.start) begin
      // Dropping start rearms the dealer for a fresh deck. Any in-flight read
      // is abandoned and the last dealt card stays visible.
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.request && !deck_empty) state <= ADDR;
        end
        ADDR:  state <= READ;
        READ:  state <= CAPTURE;
        CAPTURE: begin
          bus.card    <= bus.memData;
          bus.isAce   <= (code == 32'd1);
          bus.badCard <= (code == 32'd0) || (code > 32'd13);
          if (code == 32'd1)
            bus.points <= 4'd11;
          else if (code >= 32'd2 && code <= 32'd10)
            bus.points <= 4'(code);
          else if (code >= 32'd11 && code <= 32'd13)
            bus.points <= 4'd10;
          else
            bus.points <= 4'd0;
          // Bad codes still consume a slot. The pointer saturates at the deck size.
          if (!deck_empty) ptr <= ptr + ADDR_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The address is the pointer in every state, so it is stable from ADDR
  // through CAPTURE. The strobe and valid are gated by start so that an
  // abandoned read never looks like a completed deal.
  assign bus.nextA     = ptr;
  assign bus.memClock  = (state == READ) && bus.start;
  assign bus.cardValid = (state == CAPTURE) && bus.start;
  assign bus.busy      = (state != IDLE);
  assign bus.wren      = 1'b0;
  assign bus.empty     = deck_empty;
  assign bus.remaining = DECK - ptr;
  assign dbg_state     = state;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed bench for card_dealer. It contains a card RAM model,
// a transaction-level reference model, and a per-cycle compare process.
module tb_card_dealer;

  localparam int DECK = 52;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  card_dealer_if #(.ADDR_W(6), .DATA_W(4)) bus ();

  card_dealer #(.DECK_SIZE(DECK), .ADDR_W(6), .DATA_W(4)) dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- card RAM: data valid the cycle after the strobe ----------
  logic [3:0] ram [DECK];
  initial bus.memData = 4'd0;
  always @(posedge clk) if (bus.memClock) bus.memData <= ram[bus.nextA];

  // ---------------- counters / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Blackjack values indexed by card code.
  int pts_tbl [16] = '{0, 11, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10, 0, 0};
  int m_ptr  = 0;   // next address to deal
  int m_age  = 0;   // cycles since the request was accepted; 0 = not dealing
  int m_card = 0;
  int m_pts  = 0;
  bit m_bad  = 0;
  bit live   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ptr = 0; m_age = 0; m_card = 0; m_pts = 0; m_bad = 0; live = 1;
    end else if (!bus.start) begin
      m_age = 0; m_ptr = 0;
    end else if (m_age == 3) begin
      m_card = int'(ram[m_ptr]);
      m_pts  = pts_tbl[m_card];
      m_bad  = (m_pts == 0);
      if (m_ptr < DECK) m_ptr++;
      m_age = 0;
      exp_q.push_back(4'(m_card));
    end else if (m_age != 0) begin
      m_age++;
    end else if (bus.request && m_ptr < DECK) begin
      m_age = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (live) begin
      chk("busy",      32'(bus.busy),      32'(m_age != 0));
      chk("memClock",  32'(bus.memClock),  32'(m_age == 2 && bus.start));
      chk("cardValid", 32'(bus.cardValid), 32'(m_age == 3 && bus.start));
      chk("nextA",     32'(bus.nextA),     32'(m_ptr));
      chk("empty",     32'(bus.empty),     32'(m_ptr == DECK));
      chk("remaining", 32'(bus.remaining), 32'(DECK - m_ptr));
      chk("card",      32'(bus.card),      32'(m_card));
      chk("points",    32'(bus.points),    32'(m_pts));
      chk("isAce",     32'(bus.isAce),     32'(m_card == 1));
      chk("badCard",   32'(bus.badCard),   32'(m_bad));
      chk("wren",      32'(bus.wren),      32'd0);
      chk("dbg_busy",  32'(dbg_state != 2'd0), 32'(bus.busy));
      if (exp_q.size() > 0) chk("sb_card", 32'(bus.card), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issues a one-cycle request. lat is the number of edges to the cycle in which
  // cardValid is seen, or 99 if it never appears. The task returns just after the
  // edge that follows, when the new card is visible.
  task automatic deal(output int lat);
    lat = 99;
    bus.request = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.request = 1'b0;
      @(negedge clk);
      if (bus.cardValid) begin
        lat = k;
        break;
      end
    end
    tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lat, mc, cv, last;
    for (int i = 0; i < DECK; i++) ram[i] = 4'((i % 13) + 1);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.request = 1'b0;

    // reset values
    do_reset();
    chk("rst_remaining", 32'(bus.remaining), 32'd52);
    chk("rst_card",      32'(bus.card),      32'd0);
    chk("rst_empty",     32'(bus.empty),     32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_nextA",     32'(bus.nextA),     32'd0);

    // first card: latency 3, ace
    bus.start = 1'b1;
    tick();
    deal(lat);
    chk("t1_latency",   32'(lat),           32'd3);
    chk("t1_card",      32'(bus.card),      32'd1);
    chk("t1_points",    32'(bus.points),    32'd11);
    chk("t1_isAce",     32'(bus.isAce),     32'd1);
    chk("t1_remaining", 32'(bus.remaining), 32'd51);

    // rest of the deck, back to back
    for (int i = 1; i < DECK; i++) begin
      deal(lat);
      chk("t2_latency", 32'(lat), 32'd3);
      chk("t2_card", 32'(bus.card), 32'((i % 13) + 1));
      if (i == 11) chk("t2_q_points", 32'(bus.points), 32'd10);
    end
    chk("t2_empty",     32'(bus.empty),     32'd1);
    chk("t2_remaining", 32'(bus.remaining), 32'd0);
    chk("t2_nextA",     32'(bus.nextA),     32'd52);
    // 53rd request is ignored
    mc = 0; cv = 0;
    bus.request = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      if (bus.memClock) mc++;
      if (bus.cardValid) cv++;
    end
    tick();
    bus.request = 1'b0;
    chk("t2_extra_memClock",  32'(mc), 32'd0);
    chk("t2_extra_cardValid", 32'(cv), 32'd0);
    chk("t2_hold_card",       32'(bus.card), 32'd13);

    // request held high continuously: one deal every 4 cycles
    do_reset();
    mc = 0; cv = 0; last = -1;
    bus.request = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      @(negedge clk);
      if (bus.memClock) mc++;
      if (bus.cardValid) begin
        chk("t3_nextA", 32'(bus.nextA), 32'(cv));
        if (last >= 0) chk("t3_period", 32'(k - last), 32'd4);
        last = k;
        cv++;
      end
    end
    tick();
    bus.request = 1'b0;
    repeat (4) tick();
    chk("t3_memClock_count",  32'(mc), 32'd10);
    chk("t3_cardValid_count", 32'(cv), 32'd10);

    // bad codes at addresses 5 and 6
    ram[5] = 4'd0;
    ram[6] = 4'd14;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      deal(lat);
      if (i == 5) begin
        chk("t4_bad0_card",   32'(bus.card),    32'd0);
        chk("t4_bad0_flag",   32'(bus.badCard), 32'd1);
        chk("t4_bad0_points", 32'(bus.points),  32'd0);
      end
      if (i == 6) begin
        chk("t4_bad14_card",   32'(bus.card),    32'd14);
        chk("t4_bad14_flag",   32'(bus.badCard), 32'd1);
        chk("t4_bad14_points", 32'(bus.points),  32'd0);
      end
    end
    chk("t4_nextA",     32'(bus.nextA),     32'd7);
    chk("t4_remaining", 32'(bus.remaining), 32'd45);
    ram[5] = 4'd6;
    ram[6] = 4'd7;

    // drop start during the READ of card 10
    do_reset();
    for (int i = 0; i < 9; i++) deal(lat);
    chk("t5_card9", 32'(bus.card), 32'd9);
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("t5_abort_cardValid", 32'(bus.cardValid), 32'd0);
    tick();
    chk("t5_remaining_idle", 32'(bus.remaining), 32'd52);
    chk("t5_hold_card",      32'(bus.card),      32'd9);
    repeat (2) tick();
    bus.start = 1'b1;
    tick();
    chk("t5_remaining_rearm", 32'(bus.remaining), 32'd52);
    deal(lat);
    chk("t5_latency", 32'(lat), 32'd3);
    chk("t5_card",    32'(bus.card), 32'd1);

    // reset during CAPTURE
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_card",      32'(bus.card),      32'd0);
    chk("t6_points",    32'(bus.points),    32'd0);
    chk("t6_isAce",     32'(bus.isAce),     32'd0);
    chk("t6_empty",     32'(bus.empty),     32'd0);
    chk("t6_busy",      32'(bus.busy),      32'd0);
    chk("t6_remaining", 32'(bus.remaining), 32'd52);
    chk("t6_nextA",     32'(bus.nextA),     32'd0);

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
